// File: rtl/phase_seq_pkg.sv
// Shared constants and helpers for the phase sequencer: synchroniser depth,
// default geometry, and the one-hot test used by the ring checker.
package phase_seq_pkg;

  localparam int SYNC_STAGES  = 2;
  localparam int DEF_PHASES   = 5;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_DIV_W    = 8;
  localparam int MAX_PHASES   = 64;

  // Callers zero-extend narrower rings to MAX_PHASES bits.
  function automatic logic onehot_ok(input logic [MAX_PHASES-1:0] vec);
    int ones;
    ones = 0;
    for (int i = 0; i < MAX_PHASES; i++) begin
      ones += int'(vec[i]);
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/phase_seq_divider.sv
// One programmable clock-enable channel: counts run cycles and emits a
// single-cycle strobe every max(div,1) cycles.
module phase_seq_divider
  import phase_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             I_clock,
  input  logic             I_N_rst,
  input  logic             I_run,
  input  logic             I_resync,
  input  logic [DIV_W-1:0] I_div,
  output logic             O_ce
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_eff;
  logic             at_term;

  // A divisor of zero behaves as one; >= compare makes a lowered divisor
  // wrap immediately instead of running the counter all the way round.
  always_comb begin
    div_eff = (I_div == '0) ? DIV_W'(1) : I_div;
    at_term = (cnt_q >= (div_eff - DIV_W'(1)));
  end

  always_ff @(posedge I_clock or negedge I_N_rst) begin
    if (!I_N_rst) begin
      cnt_q <= '0;
      O_ce  <= 1'b0;
    end else if (!I_run || I_resync) begin
      cnt_q <= '0;
      O_ce  <= 1'b0;
    end else if (at_term) begin
      cnt_q <= '0;
      O_ce  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
      O_ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Lock-qualified one-hot phase ring plus CHANNELS programmable enable strobes.
// Optional ring-integrity checker enabled by defining PHASE_SEQ_RING_CHECK_EN.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int PHASES   = DEF_PHASES,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DIV_W    = DEF_DIV_W
) (
  input  logic                      I_clock,
  input  logic                      I_N_rst,
  input  logic                      I_pll_lock,
  input  logic                      I_resync,
  input  logic [CHANNELS*DIV_W-1:0] I_div,
  output logic                      O_N_reset,
  output logic [PHASES-1:0]         O_phase,
  output logic                      O_phase_0,
  output logic [CHANNELS-1:0]       O_ce,
  output logic                      O_ring_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   run;
  logic                   run_en;
  logic [PHASES-1:0]      phase_q;
  logic [PHASES-1:0]      phase_d;

  always_ff @(posedge I_clock or negedge I_N_rst) begin
    if (!I_N_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I_pll_lock};
    end
  end

  // run_en looks one stage ahead so that the ring and counters land on their
  // idle values in the same cycle O_N_reset falls, and start from them on rise.
  assign run    = sync_q[SYNC_STAGES-1];
  assign run_en = run & sync_q[SYNC_STAGES-2];

  always_comb begin
    phase_d = {phase_q[PHASES-2:0], phase_q[PHASES-1]};
    if (!run_en || I_resync) begin
      phase_d = PHASES'(1);
    end
`ifdef PHASE_SEQ_RING_CHECK_EN
    else if (!onehot_ok(MAX_PHASES'(phase_q))) begin
      phase_d = PHASES'(1);
    end
`endif
  end

  always_ff @(posedge I_clock or negedge I_N_rst) begin
    if (!I_N_rst) begin
      phase_q <= PHASES'(1);
    end else begin
      phase_q <= phase_d;
    end
  end

`ifdef PHASE_SEQ_RING_CHECK_EN
  logic err_q;

  always_ff @(posedge I_clock or negedge I_N_rst) begin
    if (!I_N_rst) begin
      err_q <= 1'b0;
    end else if (!run_en || I_resync) begin
      err_q <= 1'b0;
    end else if (!onehot_ok(MAX_PHASES'(phase_q))) begin
      err_q <= 1'b1;
    end
  end

  assign O_ring_err = err_q;
`else
  assign O_ring_err = 1'b0;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_div
    phase_seq_divider #(
      .DIV_W(DIV_W)
    ) u_div (
      .I_clock (I_clock),
      .I_N_rst (I_N_rst),
      .I_run   (run_en),
      .I_resync(I_resync),
      .I_div   (I_div[c*DIV_W +: DIV_W]),
      .O_ce    (O_ce[c])
    );
  end

  assign O_N_reset = run;
  assign O_phase   = phase_q;
  assign O_phase_0 = phase_q[0];

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed vector table, a few
// hand sequences, then randomized traffic against a cycle-level reference model.
module tb_phase_sequencer;

  localparam int P = 5;
  localparam int C = 2;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           lock = 1'b0;
  logic           resync = 1'b0;
  logic [C*W-1:0] div = '0;
  logic           n_reset;
  logic [P-1:0]   phase;
  logic           phase_0;
  logic [C-1:0]   ce;
  logic           ring_err;

  phase_sequencer #(.PHASES(P), .CHANNELS(C), .DIV_W(W)) dut (
    .I_clock   (clk),
    .I_N_rst   (rst_n),
    .I_pll_lock(lock),
    .I_resync  (resync),
    .I_div     (div),
    .O_N_reset (n_reset),
    .O_phase   (phase),
    .O_phase_0 (phase_0),
    .O_ce      (ce),
    .O_ring_err(ring_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lock seen two edges late; phase index k counts run
  // cycles since start/resync; el[c] counts cycles since the last strobe.
  bit           m_s1, m_run;
  int           m_k;
  int           m_el[C];
  logic [C-1:0] m_ce;

  typedef struct {
    logic       lk;
    logic       rs;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       e_run;
    logic [4:0] e_ph;
    logic [1:0] e_ce;
  } vec_t;
  vec_t tbl[21];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_run = 0; m_k = 0; m_ce = '0;
    for (int c = 0; c < C; c++) m_el[c] = 0;
  endtask

  task automatic model_edge();
    bit prev;
    int d;
    prev  = m_run;
    m_run = m_s1;
    m_s1  = lock;
    if (!prev || !m_run || resync) begin
      m_k = 0; m_ce = '0;
      for (int c = 0; c < C; c++) m_el[c] = 0;
    end else begin
      m_k++;
      for (int c = 0; c < C; c++) begin
        d = int'(div[c*W +: W]);
        if (d < 1) d = 1;
        if (m_el[c] >= d - 1) begin
          m_ce[c] = 1'b1; m_el[c] = 0;
        end else begin
          m_ce[c] = 1'b0; m_el[c]++;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".n_reset"}, 32'(n_reset), 32'd0);
    check({tag, ".phase"}, 32'(phase), 32'd1);
    check({tag, ".phase_0"}, 32'(phase_0), 32'd1);
    check({tag, ".ce"}, 32'(ce), 32'd0);
    check({tag, ".ring_err"}, 32'(ring_err), 32'd0);
  endtask

  task automatic async_reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_model();
    logic [P-1:0] eph;
    eph = P'(1) << (m_k % P);
    check("rnd.n_reset", 32'(n_reset), 32'(m_run));
    check("rnd.phase", 32'(phase), 32'(eph));
    check("rnd.phase_0", 32'(phase_0), 32'(eph[0]));
    check("rnd.ce", 32'(ce), 32'(m_ce));
    check("rnd.ring_err", 32'(ring_err), 32'd0);
  endtask

  initial begin
    // lk rs d0 d1 | run phase ce   (d0=3, d1=1 then 0; resync in row 14;
    // lock drop in 18, resync together with visible lock loss in 19)
    tbl[0]  = '{1'b1, 1'b0, 8'd3, 8'd1, 1'b0, 5'd1,  2'b00};
    tbl[1]  = '{1'b1, 1'b0, 8'd3, 8'd1, 1'b1, 5'd1,  2'b00};
    tbl[2]  = '{1'b1, 1'b0, 8'd3, 8'd1, 1'b1, 5'd2,  2'b10};
    tbl[3]  = '{1'b1, 1'b0, 8'd3, 8'd1, 1'b1, 5'd4,  2'b10};
    tbl[4]  = '{1'b1, 1'b0, 8'd3, 8'd1, 1'b1, 5'd8,  2'b11};
    tbl[5]  = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd16, 2'b10};
    tbl[6]  = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd1,  2'b10};
    tbl[7]  = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd2,  2'b11};
    tbl[8]  = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd4,  2'b10};
    tbl[9]  = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd8,  2'b10};
    tbl[10] = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd16, 2'b11};
    tbl[11] = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd1,  2'b10};
    tbl[12] = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd2,  2'b10};
    tbl[13] = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd4,  2'b11};
    tbl[14] = '{1'b1, 1'b1, 8'd3, 8'd0, 1'b1, 5'd1,  2'b00};
    tbl[15] = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd2,  2'b10};
    tbl[16] = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd4,  2'b10};
    tbl[17] = '{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 5'd8,  2'b11};
    tbl[18] = '{1'b0, 1'b0, 8'd3, 8'd0, 1'b1, 5'd16, 2'b10};
    tbl[19] = '{1'b0, 1'b1, 8'd3, 8'd0, 1'b0, 5'd1,  2'b00};
    tbl[20] = '{1'b0, 1'b0, 8'd3, 8'd0, 1'b0, 5'd1,  2'b00};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      lock   = tbl[i].lk;
      resync = tbl[i].rs;
      div    = {tbl[i].d1, tbl[i].d0};
      cyc();
      check($sformatf("tbl%0d.n_reset", i), 32'(n_reset), 32'(tbl[i].e_run));
      check($sformatf("tbl%0d.phase", i), 32'(phase), 32'(tbl[i].e_ph));
      check($sformatf("tbl%0d.phase_0", i), 32'(phase_0), 32'(tbl[i].e_ph[0]));
      check($sformatf("tbl%0d.ce", i), 32'(ce), 32'(tbl[i].e_ce));
    end
    resync = 1'b0;

    // Divisor lowered from 10 to 2 during run cycle 7.
    async_reset_pulse("rst_a");
    lock = 1'b1;
    div  = {8'd1, 8'd10};
    repeat (2) cyc();
    check("div_chg.run0", 32'(n_reset), 32'd1);
    repeat (7) cyc();
    check("div_chg.no_pulse7", 32'(ce[0]), 32'd0);
    div = {8'd1, 8'd2};
    for (int j = 8; j <= 12; j++) begin
      cyc();
      check($sformatf("div_chg.ce0_c%0d", j), 32'(ce[0]), 32'((j % 2) == 0));
    end

    // Async reset asserted mid-run clears outputs without a clock edge.
    async_reset_pulse("rst_mid");
    repeat (2) cyc();
    check("rst_mid.relock", 32'(n_reset), 32'd1);

`ifdef PHASE_SEQ_RING_CHECK_EN
    begin
      bit seen;
      seen = 0;
      force dut.phase_q = 5'b00110;
      @(posedge clk);
      #1;
      release dut.phase_q;
      for (int j = 0; j < 3 && !seen; j++) begin
        @(posedge clk);
        #1;
        if (phase == 5'd1 && ring_err) seen = 1;
      end
      check("ring.recover", 32'(seen), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("ring.sticky", 32'(ring_err), 32'd1);
      resync = 1'b1;
      @(posedge clk);
      #1;
      resync = 1'b0;
      check("ring.clear", 32'(ring_err), 32'd0);
    end
`else
    check("ring.tied0", 32'(ring_err), 32'd0);
`endif

    async_reset_pulse("rst_rnd");
    for (int n = 0; n < 3000; n++) begin
      lock   = ($urandom_range(0, 99) < 95) ? 1'b1 : 1'b0;
      resync = ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0;
      for (int c = 0; c < C; c++) begin
        if ($urandom_range(0, 15) == 0) div[c*W +: W] = W'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset_pulse("rnd.async");
      end
      cyc();
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised successor to the fixed 5-phase ring used in clock generation. It generates a one-hot phase ring of configurable length, CHANNELS independent programmable clock-enable strobes, and a lock-qualified synchronous reset release, all in the serial-clock domain. It sits directly after the PLL/CLKDIV stage and feeds phase and enable strobes to the TMDS serialiser and pixel pipeline.

## Interface
- PHASES, 5, ring length (≥2)
- CHANNELS, 2, number of programmable enable outputs (≥1)
- DIV_W, 8, width of each divisor field
- I_clock  in  1  serial clock; all logic on posedge
- I_N_rst  in  1  reset, asynchronous, active-low
- I_pll_lock  in  1  PLL lock, asynchronous to I_clock
- I_resync  in  1  synchronous single-cycle request to realign ring and dividers
- I_div  in  CHANNELS*DIV_W  per-channel divisor N, channel c at [c*DIV_W +: DIV_W]
- O_N_reset  out  1  synchronised run/reset-release for downstream logic
- O_phase  out  PHASES  one-hot phase ring
- O_phase_0  out  1  equals O_phase[0]
- O_ce  out  CHANNELS  one-cycle enable strobes
- O_ring_err  out  1  sticky ring-integrity error (see Configuration)

## Operation
- Reset sync: 2-flop synchroniser on I_pll_lock, asynchronously cleared by I_N_rst; O_N_reset is the second stage. Loss of lock drops O_N_reset two cycles later (synchronously). "run" below means O_N_reset high.
- Ring: while run low, O_phase = 1 (bit 0 only). While run high, it rotates left each cycle; bit PHASES-1 wraps to bit 0.
- Dividers: per channel, counter cnt (DIV_W bits) with effective divisor D = max(N,1).
  - While run low, cnt = 0 and O_ce = 0.
  - While running: if cnt ≥ D-1, then cnt←0 and O_ce[c]←1 (registered); otherwise cnt←cnt+1 and O_ce[c]←0.
  - D = 1 holds O_ce[c] high continuously.
  - The divisor is sampled every cycle. Lowering it below the current cnt causes a wrap on the next cycle, never a 2^DIV_W overrun.
- Resync: when I_resync is high in a running cycle, the next cycle has O_phase = 1, all cnt = 0, and all O_ce = 0. This takes priority over normal rotation and counting. Ignored while run is low.
- Simultaneous lock loss and resync: lock loss wins; state stays held at reset values.

## Timing
- Reset values: O_N_reset=0, O_phase=1, O_phase_0=1, O_ce=0, O_ring_err=0.
- Lock rising → O_N_reset high after 2 I_clock edges. That is run cycle 0, with O_phase=1.
- Run cycle k: O_phase = 1 << (k mod PHASES).
- First O_ce[c] pulse in run cycle D, then every D cycles.
- After resync at cycle r: O_phase=1 at r+1; first O_ce at r+1+D.
- Async I_N_rst assertion mid-operation forces all outputs to reset values immediately.

## Configuration
- PHASE_SEQ_RING_CHECK_EN defined: each running cycle checks that O_phase is exactly one-hot.
  - On violation, the next O_phase = 1 and O_ring_err sets.
  - O_ring_err is sticky until I_N_rst, lock loss, or resync.
- Undefined: no checker; O_ring_err is tied 0; the ring rotates blindly.

## Structure
- Package phase_seq_pkg holds:
  - SYNC_STAGES = 2
  - default PHASES/CHANNELS/DIV_W constants
  - function onehot_ok(vector) used by the checker
- Sub-module phase_seq_divider: one channel's counter and strobe, instantiated CHANNELS times via generate. Ports: clock, reset, run, resync, div, ce.
- Top level holds the lock synchroniser, ring, and checker.

## Test plan
- Reset held, then lock=1 → O_N_reset high after 2 edges; O_phase walks 1,2,4,8,16,1 for PHASES=5.
- div0=3, div1=1 → O_ce[0] pulses in run cycles 3,6,9; O_ce[1] high continuously; div=0 behaves as 1.
- At run cycle 7, change div0 from 10 to 2 → O_ce[0] pulses on the next cycle, then every 2 cycles.
- I_resync at cycle 12 → O_phase=1 and O_ce=0 at 13; O_ce[0] (D=3) pulses at 16; concurrent lock loss instead holds the reset state.
- Drop lock mid-run → O_N_reset low 2 edges later, O_phase=1, O_ce=0; I_N_rst low clears everything asynchronously.
- Macro defined: force O_phase=5'b00110 → next cycle O_phase=1, O_ring_err=1 until resync. Macro undefined: O_ring_err stays 0.
